// File: rtl/bus_hub_n_if.sv
// Bus bundle between one CPU data-bus host, the hub and N_DEV memory-mapped devices.
// The hub connects through the slave modport. The host and device side, such as a
// testbench or the surrounding SoC, connects through the master modport.
interface bus_hub_n_if #(
   parameter int N_DEV = 4
) ();
   // host side
   logic [31:0]         host_address;
   logic [31:0]         host_data_write;
   logic [3:0]          host_write_mask;
   logic                host_wen;
   logic                host_ren;
   logic [31:0]         host_data_read;
   logic                host_ready;
   logic                host_error;
   // device side
   logic [N_DEV*32-1:0] device_address;
   logic [N_DEV*32-1:0] device_data_write;
   logic [N_DEV*4-1:0]  device_write_mask;
   logic [N_DEV-1:0]    device_wen;
   logic [N_DEV-1:0]    device_ren;
   logic [N_DEV-1:0]    device_ready;
   logic [N_DEV*32-1:0] device_data_read;
   logic [N_DEV-1:0]    device_active;

   modport slave (
      input  host_address, host_data_write, host_write_mask, host_wen, host_ren,
      output host_data_read, host_ready, host_error,
      output device_address, device_data_write, device_write_mask,
      output device_wen, device_ren, device_active,
      input  device_ready, device_data_read
   );

   modport master (
      output host_address, host_data_write, host_write_mask, host_wen, host_ren,
      input  host_data_read, host_ready, host_error,
      input  device_address, device_data_write, device_write_mask,
      input  device_wen, device_ren, device_active,
      output device_ready, device_data_read
   );
endinterface

// File: rtl/bus_hub_n.sv
// bus_hub_n: N-device bus hub. It decodes the host address against per-device
// base/mask windows and forwards one transaction at a time. It then returns the
// data, a ready pulse and an error pulse to the host.
// Optional feature: define BUS_HUB_N_TIMEOUT_EN to force completion with an error
// after TIMEOUT_CYCLES wait cycles without device_ready.
module bus_hub_n #(
   parameter int                  N_DEV          = 4,
   parameter logic [N_DEV*32-1:0] DEV_BASE       = {N_DEV{32'h0}},
   parameter logic [N_DEV*32-1:0] DEV_MASK       = {N_DEV{32'h0}},
   parameter int                  TIMEOUT_CYCLES = 255,
   parameter logic [31:0]         ERR_RDATA      = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst_n,
   bus_hub_n_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t             state_reg, state_next;
   logic [31:0]        addr_reg, wdata_reg, rdata_reg;
   logic [3:0]         mask_reg;
   logic               write_reg, error_reg;
   logic [N_DEV-1:0]   sel_reg;

   logic               req;
   logic [N_DEV-1:0]   hit;
   logic [N_DEV-1:0]   hit_onehot;
   logic               any_hit;
   logic               dev_done;
   logic [31:0]        dev_rdata;
   logic               expire;

   assign req = bus.host_wen | bus.host_ren;

   // Per-device window match on the live host address.
   for (genvar gi = 0; gi < N_DEV; gi++) begin : g_hit
      assign hit[gi] = (bus.host_address & DEV_MASK[32*gi +: 32]) == DEV_BASE[32*gi +: 32];
   end

   // Priority select: scanning downwards means the lowest matching index is written last and wins.
   always_comb begin
      hit_onehot = '0;
      any_hit    = 1'b0;
      for (int i = N_DEV - 1; i >= 0; i--) begin
         if (hit[i]) begin
            hit_onehot    = '0;
            hit_onehot[i] = 1'b1;
            any_hit       = 1'b1;
         end
      end
   end

   // Route ready and read data from the selected device only; unselected devices are ignored.
   always_comb begin
      dev_done  = 1'b0;
      dev_rdata = '0;
      for (int i = 0; i < N_DEV; i++) begin
         if (sel_reg[i]) begin
            dev_done  = bus.device_ready[i];
            dev_rdata = bus.device_data_read[32*i +: 32];
         end
      end
   end

`ifdef BUS_HUB_N_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_reg;

   assign expire = (cnt_reg == CNT_W'(TIMEOUT_CYCLES));

   // Wait-cycle counter: cleared on entry to WAIT, saturating so it never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (state_reg == IDLE) begin
         cnt_reg <= '0;
      end else if (state_reg == WAIT && !expire) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end
`else
   assign expire = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic. A ready that arrives on the expiry cycle takes priority over the timeout.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (req) state_next = any_hit ? WAIT : RESP;
         WAIT: if (dev_done || expire) state_next = RESP;
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Latch the request in IDLE, then capture the outcome when the transaction completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg  <= '0;
         wdata_reg <= '0;
         mask_reg  <= '0;
         write_reg <= 1'b0;
         sel_reg   <= '0;
         rdata_reg <= '0;
         error_reg <= 1'b0;
      end else begin
         if (state_reg == IDLE && req) begin
            addr_reg  <= bus.host_address;
            wdata_reg <= bus.host_data_write;
            mask_reg  <= bus.host_write_mask;
            write_reg <= bus.host_wen;
            sel_reg   <= hit_onehot;
            rdata_reg <= any_hit ? 32'h0 : ERR_RDATA;
            error_reg <= ~any_hit;
         end else if (state_reg == WAIT) begin
            if (dev_done) begin
               rdata_reg <= write_reg ? 32'h0 : dev_rdata;
               error_reg <= 1'b0;
            end else if (expire) begin
               rdata_reg <= ERR_RDATA;
               error_reg <= 1'b1;
            end
         end
      end
   end

   // Host response. Outputs are decoded from registered state, so reset clears them immediately.
   assign bus.host_ready     = (state_reg == RESP);
   assign bus.host_data_read = (state_reg == RESP) ? rdata_reg : 32'h0;
   assign bus.host_error     = (state_reg == RESP) & error_reg;

   // Broadcast the latched request to every port and strobe only the selected device while waiting.
   for (genvar gi = 0; gi < N_DEV; gi++) begin : g_dev
      assign bus.device_address[32*gi +: 32]    = addr_reg;
      assign bus.device_data_write[32*gi +: 32] = wdata_reg;
      assign bus.device_write_mask[4*gi +: 4]   = mask_reg;
      assign bus.device_active[gi] = (state_reg == WAIT) & sel_reg[gi];
      assign bus.device_wen[gi]    = (state_reg == WAIT) & sel_reg[gi] & write_reg;
      assign bus.device_ren[gi]    = (state_reg == WAIT) & sel_reg[gi] & ~write_reg;
   end
endmodule
